// File: rtl/mux_arb_nto1.sv
// N-input registered multiplexer with fixed-priority or round-robin arbitration
// and a single valid/ready output stage capable of one transfer per cycle.
module mux_arb_nto1 #(
  parameter int WIDTH = 4,
  parameter int N     = 2,
  parameter int RR    = 1,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_src
);

  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SELW-1:0]  out_src_q, out_src_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  gnt_idx;
  logic             gnt_any;
  logic             can_load;
  logic             load;

  // Arbitration: scan from rr_ptr (round-robin) or from 0 (fixed priority),
  // wrapping at N so indices >= N are never produced.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = (RR != 0) ? int'(rr_ptr_q) + k : k;
      if (idx >= N) idx = idx - N;
      if (!gnt_any && in_valid[SELW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = SELW'(idx);
      end
    end
  end

  assign can_load = ~out_valid_q | out_ready;
  assign load     = gnt_any & can_load & ~rst;

  always_comb begin
    in_ready = '0;
    if (load) in_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      out_src_d   = gnt_idx;
      if (RR != 0)
        rr_ptr_d = (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + SELW'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output stage register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Bench for mux_arb_nto1: three instances (N=4 RR, N=4 fixed, N=3 W=8 RR)
// checked against a reference arbiter with a scoreboard queue per instance.
module tb_mux_arb_nto1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] a_data;  logic [3:0] a_valid, a_ready; logic [3:0] a_odata;
  logic        a_ovalid, a_oready; logic [1:0] a_src;
  logic [15:0] b_data;  logic [3:0] b_valid, b_ready; logic [3:0] b_odata;
  logic        b_ovalid, b_oready; logic [1:0] b_src;
  logic [23:0] c_data;  logic [2:0] c_valid, c_ready; logic [7:0] c_odata;
  logic        c_ovalid, c_oready; logic [1:0] c_src;

  mux_arb_nto1 #(.WIDTH(4), .N(4), .RR(1)) u_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_oready), .out_src(a_src));
  mux_arb_nto1 #(.WIDTH(4), .N(4), .RR(0)) u_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .out_data(b_odata), .out_valid(b_ovalid), .out_ready(b_oready), .out_src(b_src));
  mux_arb_nto1 #(.WIDTH(8), .N(3), .RR(1)) u_c (
    .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
    .out_data(c_odata), .out_valid(c_ovalid), .out_ready(c_oready), .out_src(c_src));

  int total = 0;
  int bad   = 0;
  int sbq [3][$];
  int lg  [3][$];
  int ptr [3];

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  function automatic int gnt(input int n, input int rr, input logic [3:0] v, input int p);
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = rr ? (p + k) % n : k;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic step(input int id);
    logic [3:0] v, r, exp_r; logic [23:0] d; logic [7:0] od;
    logic ov, ordy; logic [1:0] s;
    int n, rr, w, g, e; bit held, can_load;
    case (id)
      0: begin v = a_valid; r = a_ready; d = {8'h0, a_data}; od = {4'h0, a_odata};
               ov = a_ovalid; ordy = a_oready; s = a_src; n = 4; rr = 1; w = 4; end
      1: begin v = b_valid; r = b_ready; d = {8'h0, b_data}; od = {4'h0, b_odata};
               ov = b_ovalid; ordy = b_oready; s = b_src; n = 4; rr = 0; w = 4; end
      default: begin v = {1'b0, c_valid}; r = {1'b0, c_ready}; d = c_data; od = c_odata;
               ov = c_ovalid; ordy = c_oready; s = c_src; n = 3; rr = 1; w = 8; end
    endcase
    g = gnt(n, rr, v, ptr[id]);
    held = sbq[id].size() > 0;
    can_load = !held || ordy;
    exp_r = (g >= 0 && can_load && !rst) ? 4'(1 << g) : 4'h0;
    chk($sformatf("rdy%0d", id), int'(r), int'(exp_r));
    chk($sformatf("ovld%0d", id), int'(ov), int'(held));
    if (rst) begin
      sbq[id].delete();
      ptr[id] = 0;
      return;
    end
    if (held && ordy) begin
      e = sbq[id].pop_front();
      chk($sformatf("src%0d", id), int'(s), e >> 8);
      chk($sformatf("data%0d", id), int'(od), e & 8'hFF);
      lg[id].push_back(e >> 8);
    end
    if (exp_r != 0) begin
      sbq[id].push_back((g << 8) | (int'(d >> (g * w)) & ((1 << w) - 1)));
      if (rr) ptr[id] = (g + 1) % n;
    end
  endtask

  task automatic cyc(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      step(0); step(1); step(2);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) ptr[i] = 0;
    rst = 1'b1;
    a_data = 16'hDCBA; a_valid = 4'hF; a_oready = 1'b1;
    b_data = 16'h4321; b_valid = 4'hF; b_oready = 1'b1;
    c_data = 24'h332211; c_valid = 3'h7; c_oready = 1'b1;
    cyc(2);
    chk("rst_a_data", int'(a_odata), 0);
    chk("rst_a_src", int'(a_src), 0);
    chk("rst_c_data", int'(c_odata), 0);
    chk("rst_c_src", int'(c_src), 0);
    rst = 1'b0; b_valid = 4'h0; c_valid = 3'h0;

    // round-robin fairness over all four channels
    lg[0].delete();
    a_valid = 4'hF;
    cyc(8);
    a_valid = 4'h0;
    cyc(1);
    chk("rr_cnt", lg[0].size(), 8);
    for (int i = 0; i < 8 && i < lg[0].size(); i++) chk("rr_seq", lg[0][i], i % 4);

    // fixed priority: ch1 always beats ch3
    lg[1].delete();
    b_valid = 4'b1010;
    cyc(5);
    b_valid = 4'h0;
    cyc(1);
    chk("fp_cnt", lg[1].size(), 5);
    for (int i = 0; i < lg[1].size(); i++) chk("fp_src", lg[1][i], 1);

    // backpressure, then drain and load in the same cycle
    a_valid = 4'b0100; a_data = 16'h0500;
    cyc(1);
    a_valid = 4'b0011; a_data = 16'h0076; a_oready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("bp_data", int'(a_odata), 5);
      chk("bp_src", int'(a_src), 2);
    end
    a_oready = 1'b1;
    cyc(1);
    chk("bp_nogap", int'(a_ovalid), 1);
    chk("bp_ch0_src", int'(a_src), 0);
    chk("bp_ch0_data", int'(a_odata), 6);
    a_valid = 4'h0;
    cyc(2);

    // pointer wrap 3 -> 0
    lg[0].delete();
    a_valid = 4'b1000; a_data = 16'h9000;
    cyc(1);
    a_valid = 4'b1001; a_data = 16'h9001;
    cyc(2);
    a_valid = 4'h0;
    cyc(1);
    chk("wrap_cnt", lg[0].size(), 3);
    if (lg[0].size() == 3) begin
      chk("wrap0", lg[0][0], 3);
      chk("wrap1", lg[0][1], 0);
      chk("wrap2", lg[0][2], 3);
    end

    // N=3 round-robin, then reset drops the held word
    lg[2].delete();
    c_valid = 3'h7;
    cyc(6);
    chk("c_src6", int'(c_src), 2);
    chk("c_data6", int'(c_odata), 8'h33);
    c_valid = 3'h0; c_oready = 1'b0; rst = 1'b1;
    cyc(1);
    chk("c_rst_ovld", int'(c_ovalid), 0);
    rst = 1'b0; c_oready = 1'b1;
    cyc(2);
    chk("c_cnt", lg[2].size(), 5);
    for (int i = 0; i < lg[2].size(); i++) chk("c_seq", lg[2][i], i % 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_arb_nto1.md
Name: mux_arb_nto1

Overview:
- Parametrised N-input, WIDTH-bit registered multiplexer with built-in arbitration and valid/ready handshake.
- Replaces static select-driven 2:1 muxes wherever several producers share one consumer, e.g. writeback-source or memory-request merging in the ARM core.
- Selects one valid input per cycle by fixed priority or round-robin, and registers it in a single output stage.
- The output stage supports full-throughput back-to-back transfers.

Parameters:
- WIDTH, 4, data width per channel (>=1).
- N, 2, number of input channels (>=2).
- RR, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- SELW, $clog2(N), width of source index; derived localparam, not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  N*WIDTH  flattened channel data; channel i at bits [i*WIDTH +: WIDTH].
- in_valid  in  N  channel i holds valid data.
- in_ready  out  N  channel i transfer accepted this cycle.
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  output register holds valid data.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_src  out  SELW  index of the channel that produced out_data.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst). All state updates on rising clk.
- Reset values: out_valid=0, out_data=0, out_src=0, rr_ptr=0. All in_ready are 0 while rst=1.
- Transfer rules:
  - Input transfer on channel i when in_valid[i] & in_ready[i].
  - Output transfer when out_valid & out_ready.
- can_load = ~out_valid | out_ready.
- Grant is a one-hot combinational function of in_valid and rr_ptr:
  - RR=0: lowest set index of in_valid.
  - RR=1: first set index scanning rr_ptr, rr_ptr+1, …, N-1, 0, …, rr_ptr-1.
- in_ready[i] = grant[i] & can_load & ~rst.
  - At most one in_ready bit is high at any time.
  - in_ready may depend on in_valid; producers must not make in_valid depend on in_ready.
- Latency: one cycle. Data accepted at edge k appears on out_data with out_valid=1 after edge k.
- Load on an input transfer:
  - out_data <= in_data of the granted channel, out_src <= granted index, out_valid <= 1.
  - If RR=1: rr_ptr <= (granted index + 1) mod N. Wrap from N-1 goes to 0.
- Drain with no load: an output transfer with no input transfer in the same cycle sets out_valid <= 0. out_data and out_src hold their last values.
- Simultaneous drain and load: the new data is loaded, out_valid stays 1, and there is no bubble. Sustained throughput is one word per cycle.
- Stall: out_valid=1 & out_ready=0 ⇒ all in_ready=0. out_data and out_src stay stable until the transfer completes.
- No valid inputs: no grant, registers unchanged, rr_ptr unchanged.
- rr_ptr changes only on an input transfer and is ignored when RR=0.
- Reset mid-operation: clears the output register and rr_ptr and drops any held word. No input transfer completes in the reset cycle.
- N not a power of two: rr_ptr wraps at N; index values ≥N are never generated.

Test Plan (N=4, WIDTH=4 unless noted):
- Reset: rst=1 for 2 cycles with in_valid=4'b1111 → out_valid=0, out_data=0, out_src=0, in_ready=0 throughout.
- Round-robin fairness: in_valid=4'b1111, out_ready=1, data ch0..3 = 4'hA,B,C,D for 8 cycles → out_src sequence 0,1,2,3,0,1,2,3 with matching data; exactly one in_ready high per cycle.
- Fixed priority (RR=0): in_valid=4'b1010, out_ready=1 → out_src=1 and out_data=ch1 every cycle; in_ready[3] never asserted.
- Backpressure: load ch2=4'h5, then out_ready=0 for 3 cycles while in_valid=4'b0011 → out_data stays 4'h5, out_src=2, in_ready=0. Then out_ready=1 → ch0 loads in the same cycle as the drain, with no out_valid gap.
- Pointer wrap: only ch3 valid for one transfer, then in_valid=4'b1001 → next grant is ch0 (rr_ptr wrapped 3→0), then ch3.
- N=3, WIDTH=8: in_valid=3'b111 for 6 transfers → out_src 0,1,2,0,1,2. Assert rst mid-stream → out_valid=0 next cycle and the held word is dropped.
